// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared opcodes, FSM states and flag bit positions for the write-back stage
//
// Contents:
//   OP_*          5-bit opcode values decoded by the stage
//   wb_state_e    write-back sequencer states
//   FLAG_*        bit positions inside flags_q ({parity,ac,carry,zero})
//   is_flag_op()  opcodes that update the architectural flags

package wb_pkg;

  localparam logic [4:0] OP_NOP   = 5'd0;
  localparam logic [4:0] OP_ADD   = 5'd1;
  localparam logic [4:0] OP_SUB   = 5'd2;
  localparam logic [4:0] OP_AND   = 5'd3;
  localparam logic [4:0] OP_OR    = 5'd4;
  localparam logic [4:0] OP_XOR   = 5'd5;
  localparam logic [4:0] OP_MUL   = 5'd6;
  localparam logic [4:0] OP_MOV   = 5'd7;
  localparam logic [4:0] OP_STORE = 5'd8;
  localparam logic [4:0] OP_JMP   = 5'd9;
  localparam logic [4:0] OP_JZ    = 5'd10;
  localparam logic [4:0] OP_JC    = 5'd11;
  localparam logic [4:0] OP_HLT   = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MUL_HI = 2'd1,
    ST_HALT   = 2'd2
  } wb_state_e;

  localparam int FLAG_ZERO   = 0;
  localparam int FLAG_CARRY  = 1;
  localparam int FLAG_AC     = 2;
  localparam int FLAG_PARITY = 3;

  // ALU ops (ADD..XOR) and MUL refresh the flags; everything else preserves them.
  function automatic logic is_flag_op(input logic [4:0] op);
    return (op >= OP_ADD) && (op <= OP_MUL);
  endfunction

endpackage

// File: rtl/wb_fsm.sv
// rtl/wb_fsm.sv - write-back sequencer: destination select, MUL byte split, jumps, halt
//
// Ports:
//   clk, rst                 clock, async active-low reset
//   in_valid / in_ready      EX/WB handshake (in_ready gated by reset)
//   ex_*                     EX/WB bundle fields
//   flag_zero, flag_carry    current architectural flags, for JZ/JC
//   rf_we/rf_waddr/rf_wdata  registered register-file write port
//   dm_we/dm_waddr/dm_wdata  registered data-memory write port
//   pc_load/pc_target        registered fetch redirect
//   halted                   registered halt indication
//   flags_load               pulse: load flags at this edge
//   retire                   pulse: one instruction completes at this edge

module wb_fsm
  import wb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  ex_opcode,
  input  logic        ex_am,
  input  logic [2:0]  ex_rd,
  input  logic [3:0]  ex_mem_addr,
  input  logic [5:0]  ex_instr_mem_addr,
  input  logic [15:0] ex_result,
  input  logic        flag_zero,
  input  logic        flag_carry,
  output logic        rf_we,
  output logic [2:0]  rf_waddr,
  output logic [7:0]  rf_wdata,
  output logic        dm_we,
  output logic [3:0]  dm_waddr,
  output logic [7:0]  dm_wdata,
  output logic        pc_load,
  output logic [5:0]  pc_target,
  output logic        halted,
  output logic        flags_load,
  output logic        retire
);

  wb_state_e  state;
  logic       xfer;

  // Pending MUL high-byte write, captured at the MUL transfer.
  logic       hi_am;
  logic [2:0] hi_rd;
  logic [3:0] hi_mem;
  logic [7:0] hi_data;

  // Gating with rst keeps in_ready low for the whole reset window while
  // still letting the first edge after release accept a bundle.
  assign in_ready   = rst && (state == ST_IDLE);
  assign xfer       = in_valid && in_ready;
  assign flags_load = xfer && is_flag_op(ex_opcode);
  // MUL retires when its second byte is written, not at its transfer.
  assign retire     = (xfer && (ex_opcode != OP_MUL)) || (state == ST_MUL_HI);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      dm_we     <= 1'b0;
      dm_waddr  <= '0;
      dm_wdata  <= '0;
      pc_load   <= 1'b0;
      pc_target <= '0;
      halted    <= 1'b0;
      hi_am     <= 1'b0;
      hi_rd     <= '0;
      hi_mem    <= '0;
      hi_data   <= '0;
    end else begin
      rf_we   <= 1'b0;
      dm_we   <= 1'b0;
      pc_load <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (xfer) begin
            case (ex_opcode)
              OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MOV, OP_MUL: begin
                if (ex_am) begin
                  dm_we    <= 1'b1;
                  dm_waddr <= ex_mem_addr;
                  dm_wdata <= ex_result[7:0];
                end else begin
                  rf_we    <= 1'b1;
                  rf_waddr <= ex_rd;
                  rf_wdata <= ex_result[7:0];
                end
                if (ex_opcode == OP_MUL) begin
                  hi_am   <= ex_am;
                  hi_rd   <= ex_rd + 3'd1;
                  hi_mem  <= ex_mem_addr + 4'd1;
                  hi_data <= ex_result[15:8];
                  state   <= ST_MUL_HI;
                end
              end
              OP_STORE: begin
                dm_we    <= 1'b1;
                dm_waddr <= ex_mem_addr;
                dm_wdata <= ex_result[7:0];
              end
              OP_JMP: begin
                pc_load   <= 1'b1;
                pc_target <= ex_instr_mem_addr;
              end
              OP_JZ: begin
                if (flag_zero) begin
                  pc_load   <= 1'b1;
                  pc_target <= ex_instr_mem_addr;
                end
              end
              OP_JC: begin
                if (flag_carry) begin
                  pc_load   <= 1'b1;
                  pc_target <= ex_instr_mem_addr;
                end
              end
              OP_HLT: begin
                halted <= 1'b1;
                state  <= ST_HALT;
              end
              default: ;
            endcase
          end
        end
        ST_MUL_HI: begin
          if (hi_am) begin
            dm_we    <= 1'b1;
            dm_waddr <= hi_mem;
            dm_wdata <= hi_data;
          end else begin
            rf_we    <= 1'b1;
            rf_waddr <= hi_rd;
            rf_wdata <= hi_data;
          end
          state <= ST_IDLE;
        end
        ST_HALT: ;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - write-back stage top: architectural flags, retire counter, sequencer
//
// Ports:
//   clk, rst                       clock, async active-low reset
//   in_valid / in_ready            EX/WB handshake
//   ex_opcode, ex_am, ex_rd,
//   ex_mem_addr, ex_instr_mem_addr,
//   ex_result, ex_zero, ex_carry,
//   ex_ac, ex_parity               EX/WB bundle
//   rf_we, rf_waddr, rf_wdata      register-file write port
//   dm_we, dm_waddr, dm_wdata      data-memory write port
//   flags_q                        {parity,ac,carry,zero}
//   pc_load, pc_target             fetch redirect
//   halted, retired_cnt            halt status, completed-instruction count

module wb_stage
  import wb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  ex_opcode,
  input  logic        ex_am,
  input  logic [2:0]  ex_rd,
  input  logic [3:0]  ex_mem_addr,
  input  logic [5:0]  ex_instr_mem_addr,
  input  logic [15:0] ex_result,
  input  logic        ex_zero,
  input  logic        ex_carry,
  input  logic        ex_ac,
  input  logic        ex_parity,
  output logic        rf_we,
  output logic [2:0]  rf_waddr,
  output logic [7:0]  rf_wdata,
  output logic        dm_we,
  output logic [3:0]  dm_waddr,
  output logic [7:0]  dm_wdata,
  output logic [3:0]  flags_q,
  output logic        pc_load,
  output logic [5:0]  pc_target,
  output logic        halted,
  output logic [7:0]  retired_cnt
);

  logic       flags_load;
  logic       retire;
  logic [3:0] ex_flags;

  always_comb begin
    ex_flags              = '0;
    ex_flags[FLAG_ZERO]   = ex_zero;
    ex_flags[FLAG_CARRY]  = ex_carry;
    ex_flags[FLAG_AC]     = ex_ac;
    ex_flags[FLAG_PARITY] = ex_parity;
  end

  wb_fsm u_fsm (
    .clk               (clk),
    .rst               (rst),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .ex_opcode         (ex_opcode),
    .ex_am             (ex_am),
    .ex_rd             (ex_rd),
    .ex_mem_addr       (ex_mem_addr),
    .ex_instr_mem_addr (ex_instr_mem_addr),
    .ex_result         (ex_result),
    .flag_zero         (flags_q[FLAG_ZERO]),
    .flag_carry        (flags_q[FLAG_CARRY]),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .dm_we             (dm_we),
    .dm_waddr          (dm_waddr),
    .dm_wdata          (dm_wdata),
    .pc_load           (pc_load),
    .pc_target         (pc_target),
    .halted            (halted),
    .flags_load        (flags_load),
    .retire            (retire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flags_q     <= '0;
      retired_cnt <= '0;
    end else begin
      if (flags_load) flags_q <= ex_flags;
      if (retire) retired_cnt <= retired_cnt + 8'd1;
    end
  end

endmodule
